// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the MEM-stage load/store port with wait states,
// RV32 lane steering, sign/zero extension and access-fault detection over a private word RAM.
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [2:0]      funct3_i,
    output logic            ready_o,
    output logic            rvalid_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept, enter_resp;

    logic            we_p0;
    logic [XLEN-1:0] addr_p0;
    logic [XLEN-1:0] wdata_p0;
    logic [2:0]      funct3_p0;

    logic            acc_we;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [2:0]      acc_f3;
    logic            acc_err;
    logic            commit;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [XLEN-1:0] wword;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                          input logic [XLEN-1:0] addr);
        logic bad;
        case (f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = addr[0];
            3'b010:         bad = (addr[1:0] != 2'b00);
            3'b100, 3'b101: bad = we | ((f3 == 3'b101) & addr[0]);
            default:        bad = 1'b1;
        endcase
        // No aliasing: any address bit above the RAM window is a fault.
        return bad | ((addr >> (AW + 2)) != '0);
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] word,
                                                    input logic [1:0] ln);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage p0: request capture at accept (data only, no reset needed)
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_p0     <= we_i;
            addr_p0   <= addr_i;
            wdata_p0  <= wdata_i;
            funct3_p0 <= funct3_i;
        end
    end

    // With zero wait states the access executes on the accept edge, so take the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
            acc_f3    = funct3_i;
        end else begin
            acc_we    = we_p0;
            acc_addr  = addr_p0;
            acc_wdata = wdata_p0;
            acc_f3    = funct3_p0;
        end
    end

    always_comb begin
        acc_err = access_fault(acc_we, acc_f3, acc_addr);
        commit  = enter_resp & acc_we & ~acc_err;
        idx     = acc_addr[AW+1:2];
        lane    = acc_addr[1:0];
        be      = 4'b0000;
        wword   = acc_wdata;
        case (acc_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wword = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{acc_wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // Stage p1: RAM read/commit on the edge that enters RESP
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= acc_err;
            rdata_q <= (acc_we || acc_err) ? '0 : load_extend(acc_f3, mem[idx], lane);
        end
    end

    assign ready_o  = (state_q == S_IDLE) && rst_i;
    assign rvalid_o = (state_q == S_RESP);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (1 and 3 wait states) checked against a byte-level
// memory model with directed RV32 cases, reset-abort scenarios and random traffic.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [2:0]  f3 = '0;
    logic        ready_a, rvalid_a, err_a, ready_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int errors = 0;
    int checks = 0;
    logic [7:0] mb [int];

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_a), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .funct3_i(f3), .ready_o(ready_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a));

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_b), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .funct3_i(f3), .ready_o(ready_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: RV32 access rules applied to a byte-addressed memory.
    task automatic model(input int sel, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] fn, output logic [31:0] rd, output logic e);
        int size;
        longint val;
        case (fn)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        e = (size == 0) || (w && fn >= 3'd4);
        if (!e) e = ((a % size) != 0) || (longint'(a) >= longint'(DEPTH) * 4);
        rd = '0;
        if (!e && w) begin
            for (int i = 0; i < size; i++) mb[sel * 65536 + int'(a) + i] = wd[8*i +: 8];
        end else if (!e) begin
            val = 0;
            for (int i = 0; i < size; i++) val += longint'(mb[sel * 65536 + int'(a) + i]) << (8 * i);
            if (fn < 3'd4 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= longint'(1) << (8 * size);
            rd = val[31:0];
        end
    endtask

    task automatic run(input int sel, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] fn, input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_e, e;
        int k;
        @(negedge clk);
        we = w; addr = a; wdata = wd; f3 = fn;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        check({tag, ":ready"}, 32'((sel == 0) ? ready_a : ready_b), 32'd1);
        @(posedge clk);
        #1;
        req_a = 1'b0; req_b = 1'b0;
        we = $urandom; addr = $urandom; wdata = $urandom; f3 = 3'($urandom);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!((sel == 0) ? rvalid_a : rvalid_b) && k < 20);
        check({tag, ":latency"}, 32'(k), (sel == 0) ? 32'd2 : 32'd4);
        rd = (sel == 0) ? rdata_a : rdata_b;
        e  = (sel == 0) ? err_a : err_b;
        model(sel, w, a, wd, fn, exp_rd, exp_e);
        check({tag, ":rdata"}, rd, exp_rd);
        check({tag, ":err"}, 32'(e), 32'(exp_e));
        @(negedge clk);
        check({tag, ":pulse"}, 32'((sel == 0) ? rvalid_a : rvalid_b), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  fsel [8];
        int seen;
        fsel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

        #12;
        check("rst:ready", 32'(ready_a), 32'd0);
        check("rst:rvalid", 32'(rvalid_a), 32'd0);
        check("rst:rdata", rdata_a, 32'd0);
        check("rst:err", 32'(err_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel:ready_a", 32'(ready_a), 32'd1);
        check("rel:ready_b", 32'(ready_b), 32'd1);

        for (int i = 0; i < 16; i++) run(0, 1'b1, 32'(i * 4), $urandom, 3'd2, "init_a", rd);
        run(1, 1'b1, 32'h20, 32'hCAFEF00D, 3'd2, "init_b", rd);

        run(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw10", rd);
        run(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10", rd);
        check("lw10:const", rd, 32'hDEADBEEF);
        run(0, 1'b1, 32'h11, 32'h80, 3'd0, "sb11", rd);
        run(0, 1'b0, 32'h11, 32'h0, 3'd0, "lb11", rd);
        check("lb11:const", rd, 32'hFFFFFF80);
        run(0, 1'b0, 32'h11, 32'h0, 3'd4, "lbu11", rd);
        check("lbu11:const", rd, 32'h00000080);
        run(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10b", rd);
        check("lw10b:const", rd, 32'hDEAD80EF);
        run(0, 1'b0, 32'h12, 32'h0, 3'd1, "lh12", rd);
        check("lh12:const", rd, 32'hFFFFDEAD);
        run(0, 1'b0, 32'h12, 32'h0, 3'd5, "lhu12", rd);
        check("lhu12:const", rd, 32'h0000DEAD);
        run(0, 1'b1, 32'h13, 32'h5555, 3'd1, "sh13", rd);
        check("sh13:err", 32'(err_a), 32'd1);
        run(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10c", rd);
        check("lw10c:const", rd, 32'hDEAD80EF);

        run(0, 1'b0, 32'h0, 32'h0, 3'd2, "lw0pre", rd);
        run(0, 1'b1, 32'(DEPTH * 4), 32'h0BADF00D, 3'd2, "sw_oor", rd);
        check("sw_oor:err", 32'(err_a), 32'd1);
        run(0, 1'b0, 32'h0, 32'h0, 3'd2, "lw0post", rd);
        run(0, 1'b0, 32'h4, 32'h0, 3'd3, "f3_011", rd);
        check("f3_011:err", 32'(err_a), 32'd1);
        run(0, 1'b1, 32'h4, 32'h1234, 3'd4, "sbu_ill", rd);
        run(0, 1'b0, 32'h4, 32'h0, 3'd2, "lw4", rd);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'(DEPTH * 4 + $urandom_range(0, 63))
                                             : 32'($urandom_range(0, 63));
            run(0, 1'($urandom), a, $urandom, fsel[$urandom_range(0, 7)], "rand", rd);
        end

        // Store on the 3-wait-state responder aborted by reset during WAIT.
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; f3 = 3'd2; req_b = 1'b1;
        req_a = 1'b1;
        @(posedge clk);
        #1;
        req_b = 1'b0; req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort:ready_b", 32'(ready_b), 32'd0);
        check("abort:rvalid_b", 32'(rvalid_b), 32'd0);
        check("abort:rdata_a", rdata_a, 32'd0);
        check("abort:rvalid_a", 32'(rvalid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort:ready_rel", 32'(ready_b), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rvalid_a || rvalid_b) seen++;
        end
        check("abort:no_rvalid", 32'(seen), 32'd0);
        run(1, 1'b0, 32'h20, 32'h0, 3'd2, "lw20_b", rd);
        check("lw20_b:const", rd, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++)
            run(1, 1'($urandom), 32'h20 + 32'($urandom_range(0, 7)), $urandom,
                fsel[$urandom_range(0, 7)], "rand_b", rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
